// File: rtl/psram_responder_pkg.sv
// Shared types and constants for the cellular-RAM responder: FSM encoding,
// byte-lane indices, strobe polarity and the bus configuration register default.
package psram_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_WAIT   = 3'd1,
        ST_RD_DRIVE  = 3'd2,
        ST_WR_WAIT   = 3'd3,
        ST_WR_COMMIT = 3'd4,
        ST_WR_HOLD   = 3'd5
    } state_t;

    localparam int          LANE_LO       = 0;
    localparam int          LANE_HI       = 1;
    localparam logic        STROBE_ON     = 1'b0;
    localparam logic [15:0] BCR_DEFAULT_C = 16'h9D1F;
    localparam int          CNT_W         = 8;

    // All bus strobes are active-low; this keeps the polarity in one place.
    function automatic logic strobe_active(input logic strobe_n);
        return strobe_n == STROBE_ON;
    endfunction

endpackage

// File: rtl/psram_responder_storage.sv
// Word array with per-byte-lane write enables and a one-cycle synchronous read.
// Contents are deliberately not reset.
module psram_responder_storage
    import psram_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int DATA_SIZE  = 16
) (
    input  logic                  clk,
    input  logic [DEPTH_LOG2-1:0] i_rd_addr,
    output logic [DATA_SIZE-1:0]  o_rd_data,
    input  logic                  i_wr_en,
    input  logic [DEPTH_LOG2-1:0] i_wr_addr,
    input  logic [DATA_SIZE-1:0]  i_wr_data,
    input  logic [1:0]            i_wr_lane
);

    localparam int LANE_W = DATA_SIZE / 2;

    logic [DATA_SIZE-1:0] r_mem [0:(1 << DEPTH_LOG2) - 1];
    logic [DATA_SIZE-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            if (i_wr_lane[LANE_LO]) begin
                r_mem[i_wr_addr][LANE_W-1:0] <= i_wr_data[LANE_W-1:0];
            end
            if (i_wr_lane[LANE_HI]) begin
                r_mem[i_wr_addr][DATA_SIZE-1:LANE_W] <= i_wr_data[DATA_SIZE-1:LANE_W];
            end
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/psram_responder.sv
// Memory-side responder for the controller's async-page cellular-RAM bus:
// latency-modelled reads/writes, byte lanes, config register, sticky abort flag.
module psram_responder
    import psram_responder_pkg::*;
#(
    parameter int                   ADDRESS_SIZE  = 24,
    parameter int                   DATA_SIZE     = 16,
    parameter int                   DEPTH_LOG2    = 10,
    parameter int                   READ_LATENCY  = 3,
    parameter int                   WRITE_LATENCY = 2,
    parameter logic [DATA_SIZE-1:0] BCR_DEFAULT   = BCR_DEFAULT_C
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDRESS_SIZE-1:0] mem_addr,
    input  logic [DATA_SIZE-1:0]    mem_data_in,
    output logic [DATA_SIZE-1:0]    mem_data_out,
    output logic                    mem_data_oe,
    input  logic                    mt_ce,
    input  logic                    mt_adv,
    input  logic                    mt_cre,
    input  logic                    outputEnable,
    input  logic                    writeEnable,
    input  logic                    lowerByte,
    input  logic                    upperByte,
    output logic                    mt_wait,
    output logic                    err_abort,
    output state_t                  o_dbg_state
);

    localparam int               LANE_W      = DATA_SIZE / 2;
    localparam logic [CNT_W-1:0] RD_CNT_INIT = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_CNT_INIT = CNT_W'(WRITE_LATENCY - 1);

    state_t                r_state;
    state_t                w_nxt_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_nxt_cnt;
    logic [DEPTH_LOG2-1:0] r_addr;
    logic [DEPTH_LOG2-1:0] w_nxt_addr;
    logic                  r_cre;
    logic                  w_nxt_cre;
    logic                  r_err;
    logic                  w_nxt_err;
    logic                  w_commit;
    logic [DATA_SIZE-1:0]  r_bcr;
    logic [DATA_SIZE-1:0]  r_data_out;
    logic [DATA_SIZE-1:0]  w_nxt_data_out;
    logic                  r_data_oe;
    logic                  w_nxt_oe;
    logic                  r_wait;
    logic                  w_nxt_wait;
    logic [DEPTH_LOG2-1:0] w_rd_addr;
    logic [DATA_SIZE-1:0]  w_rd_data;
    logic [DATA_SIZE-1:0]  w_src_word;
    logic                  w_ce_on;
    logic                  w_unused_addr;

    assign w_ce_on       = strobe_active(mt_ce);
    assign w_unused_addr = ^mem_addr[ADDRESS_SIZE-1:DEPTH_LOG2];

    // Read the incoming address while idle so data is ready even at latency 1.
    assign w_rd_addr = (r_state == ST_IDLE) ? mem_addr[DEPTH_LOG2-1:0] : r_addr;

    psram_responder_storage #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_SIZE  (DATA_SIZE)
    ) u_storage (
        .clk       (clk),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data),
        .i_wr_en   (w_commit && !r_cre),
        .i_wr_addr (r_addr),
        .i_wr_data (mem_data_in),
        .i_wr_lane ({strobe_active(upperByte), strobe_active(lowerByte)})
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_addr  = r_addr;
        w_nxt_cre   = r_cre;
        w_nxt_err   = r_err;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ce_on && strobe_active(mt_adv)) begin
                    // Write wins when both strobes are low at the start edge.
                    if (strobe_active(writeEnable)) begin
                        w_nxt_state = ST_WR_WAIT;
                        w_nxt_cnt   = WR_CNT_INIT;
                        w_nxt_addr  = mem_addr[DEPTH_LOG2-1:0];
                        w_nxt_cre   = mt_cre;
                    end else if (strobe_active(outputEnable)) begin
                        w_nxt_state = ST_RD_WAIT;
                        w_nxt_cnt   = RD_CNT_INIT;
                        w_nxt_addr  = mem_addr[DEPTH_LOG2-1:0];
                        w_nxt_cre   = mt_cre;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (!w_ce_on || !strobe_active(outputEnable)) begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_err   = 1'b1;
                end else if (r_cnt == '0) begin
                    w_nxt_state = ST_RD_DRIVE;
                end else begin
                    w_nxt_cnt = r_cnt - CNT_W'(1);
                end
            end
            ST_RD_DRIVE: begin
                if (!w_ce_on || !strobe_active(outputEnable)) begin
                    w_nxt_state = ST_IDLE;
                end
            end
            ST_WR_WAIT: begin
                if (!w_ce_on || !strobe_active(writeEnable)) begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_err   = 1'b1;
                end else if (r_cnt == '0) begin
                    w_nxt_state = ST_WR_COMMIT;
                end else begin
                    w_nxt_cnt = r_cnt - CNT_W'(1);
                end
            end
            ST_WR_COMMIT: begin
                w_commit    = 1'b1;
                w_nxt_state = ST_WR_HOLD;
            end
            ST_WR_HOLD: begin
                if (!w_ce_on || !strobe_active(writeEnable)) begin
                    w_nxt_state = ST_IDLE;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the transition edge.
    assign w_src_word = r_cre ? r_bcr : w_rd_data;
    assign w_nxt_oe   = (w_nxt_state == ST_RD_DRIVE);
    assign w_nxt_wait = (w_nxt_state == ST_RD_WAIT) || (w_nxt_state == ST_WR_WAIT);

    always_comb begin
        w_nxt_data_out = '0;
        if (w_nxt_oe) begin
            if (strobe_active(lowerByte)) begin
                w_nxt_data_out[LANE_W-1:0] = w_src_word[LANE_W-1:0];
            end
            if (strobe_active(upperByte)) begin
                w_nxt_data_out[DATA_SIZE-1:LANE_W] = w_src_word[DATA_SIZE-1:LANE_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_addr     <= '0;
            r_cre      <= 1'b0;
            r_err      <= 1'b0;
            r_bcr      <= BCR_DEFAULT;
            r_data_out <= '0;
            r_data_oe  <= 1'b0;
            r_wait     <= 1'b0;
        end else begin
            r_cnt      <= w_nxt_cnt;
            r_addr     <= w_nxt_addr;
            r_cre      <= w_nxt_cre;
            r_err      <= w_nxt_err;
            r_data_out <= w_nxt_data_out;
            r_data_oe  <= w_nxt_oe;
            r_wait     <= w_nxt_wait;
            if (w_commit && r_cre) begin
                r_bcr <= mem_data_in;
            end
        end
    end

    assign mem_data_out = r_data_out;
    assign mem_data_oe  = r_data_oe;
    assign mt_wait      = r_wait;
    assign err_abort    = r_err;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_psram_responder.sv
// Scenario bench for psram_responder: bus driver tasks, expected-data queue
// filled when a read is issued and drained when the responder drives the bus.
module tb_psram_responder;
    import psram_responder_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] mem_addr = '0;
    logic [15:0] mem_data_in = '0;
    logic [15:0] mem_data_out;
    logic        mem_data_oe;
    logic        mt_ce = 1'b1;
    logic        mt_adv = 1'b1;
    logic        mt_cre = 1'b0;
    logic        outputEnable = 1'b1;
    logic        writeEnable = 1'b1;
    logic        lowerByte = 1'b1;
    logic        upperByte = 1'b1;
    logic        mt_wait;
    logic        err_abort;
    state_t      dbg_state;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] model [0:1023];

    psram_responder dut (
        .clk          (clk),
        .rst          (rst),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_data_oe  (mem_data_oe),
        .mt_ce        (mt_ce),
        .mt_adv       (mt_adv),
        .mt_cre       (mt_cre),
        .outputEnable (outputEnable),
        .writeEnable  (writeEnable),
        .lowerByte    (lowerByte),
        .upperByte    (upperByte),
        .mt_wait      (mt_wait),
        .err_abort    (err_abort),
        .o_dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic idle_bus();
        mt_ce = 1'b1; mt_adv = 1'b1; outputEnable = 1'b1; writeEnable = 1'b1;
        lowerByte = 1'b1; upperByte = 1'b1; mt_cre = 1'b0;
    endtask

    task automatic do_write(input logic [23:0] addr, input logic [15:0] data,
                            input logic lb_n, input logic ub_n, input logic cre);
        int wcnt = 0;
        bit done = 1'b0;
        bit oe_seen = 1'b0;
        mem_addr = addr; mem_data_in = data; lowerByte = lb_n; upperByte = ub_n; mt_cre = cre;
        mt_ce = 1'b0; mt_adv = 1'b0; writeEnable = 1'b0; outputEnable = 1'b1;
        @(posedge clk); #1 mt_adv = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (mem_data_oe) oe_seen = 1'b1;
            if (mt_wait) wcnt++; else done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++; $display("FAIL write_timeout addr=%h wait stuck high", addr);
        end else if (wcnt !== 2) begin
            errors++; $display("FAIL write_wait_cycles got=%0d exp=2", wcnt);
        end
        checks++;
        if (oe_seen) begin
            errors++; $display("FAIL write_oe got=1 exp=0 during write");
        end
        @(posedge clk); #1 writeEnable = 1'b1; mt_ce = 1'b1;
        @(posedge clk); #1 idle_bus();
    endtask

    task automatic do_read(input logic [23:0] addr, input logic lb_n, input logic ub_n,
                           input logic cre);
        int wcnt = 0;
        bit done = 1'b0;
        logic [15:0] exp;
        mem_addr = addr; lowerByte = lb_n; upperByte = ub_n; mt_cre = cre;
        mt_ce = 1'b0; mt_adv = 1'b0; outputEnable = 1'b0; writeEnable = 1'b1;
        @(posedge clk); #1 mt_adv = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (mem_data_oe) done = 1'b1;
            else if (mt_wait) wcnt++;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        checks++;
        if (!done) begin
            errors++; $display("FAIL read_timeout addr=%h no data driven", addr);
        end else begin
            if (wcnt !== 3) begin
                errors++; $display("FAIL read_wait_cycles got=%0d exp=3", wcnt);
            end
            checks++;
            if (mem_data_out !== exp) begin
                errors++; $display("FAIL read_data addr=%h got=%h exp=%h", addr, mem_data_out, exp);
            end
        end
        @(posedge clk); #1 outputEnable = 1'b1; mt_ce = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if (mem_data_oe !== 1'b0) begin
            errors++; $display("FAIL read_release got=%b exp=0", mem_data_oe);
        end
        idle_bus();
    endtask

    task automatic test_reset();
        idle_bus();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (mem_data_oe !== 1'b0 || mt_wait !== 1'b0 || err_abort !== 1'b0) begin
            errors++; $display("FAIL reset_flags got oe=%b wait=%b err=%b exp 0/0/0",
                               mem_data_oe, mt_wait, err_abort);
        end
        checks++;
        if (mem_data_out !== 16'h0000 || dbg_state !== ST_IDLE) begin
            errors++; $display("FAIL reset_state got data=%h st=%0d exp 0000/IDLE",
                               mem_data_out, dbg_state);
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_write_read();
        do_write(24'h000010, 16'hA55A, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(16'hA55A);
        do_read(24'h000010, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_lanes();
        do_write(24'h000020, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        do_write(24'h000020, 16'h1234, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(16'hFF34);
        do_read(24'h000020, 1'b0, 1'b0, 1'b0);
        do_write(24'h000020, 16'h0000, 1'b1, 1'b1, 1'b0);
        exp_q.push_back(16'hFF34);
        do_read(24'h000020, 1'b0, 1'b0, 1'b0);
        checks++;
        if (err_abort !== 1'b0) begin
            errors++; $display("FAIL no_lane_err got=%b exp=0", err_abort);
        end
        exp_q.push_back(16'hFF00);
        do_read(24'h000020, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(16'h0034);
        do_read(24'h000020, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_alias();
        do_write(24'h000400, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(16'hBEEF);
        do_read(24'h000000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_cre();
        do_write(24'h000000, 16'h0001, 1'b1, 1'b1, 1'b1);
        exp_q.push_back(16'h0001);
        do_read(24'h000000, 1'b0, 1'b0, 1'b1);
        exp_q.push_back(16'hBEEF);
        do_read(24'h000000, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        exp_q.push_back(16'h9D1F);
        do_read(24'h000000, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_abort();
        do_write(24'h000030, 16'h5555, 1'b0, 1'b0, 1'b0);
        mem_addr = 24'h000030; mem_data_in = 16'hAAAA; lowerByte = 1'b0; upperByte = 1'b0;
        mt_ce = 1'b0; mt_adv = 1'b0; writeEnable = 1'b0;
        @(posedge clk); #1 mt_ce = 1'b1; writeEnable = 1'b1; mt_adv = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if (err_abort !== 1'b1 || mt_wait !== 1'b0 || dbg_state !== ST_IDLE) begin
            errors++; $display("FAIL abort_flags got err=%b wait=%b st=%0d exp 1/0/IDLE",
                               err_abort, mt_wait, dbg_state);
        end
        idle_bus();
        exp_q.push_back(16'h5555);
        do_read(24'h000030, 1'b0, 1'b0, 1'b0);
        checks++;
        if (err_abort !== 1'b1) begin
            errors++; $display("FAIL abort_sticky got=%b exp=1", err_abort);
        end
    endtask

    task automatic test_reset_mid_read();
        do_write(24'h000040, 16'h7777, 1'b0, 1'b0, 1'b0);
        mem_addr = 24'h000040; lowerByte = 1'b0; upperByte = 1'b0;
        mt_ce = 1'b0; mt_adv = 1'b0; outputEnable = 1'b0;
        @(posedge clk); #1 mt_adv = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if (mt_wait !== 1'b1) begin
            errors++; $display("FAIL midread_wait got=%b exp=1", mt_wait);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (mem_data_oe !== 1'b0 || mt_wait !== 1'b0 || dbg_state !== ST_IDLE || err_abort !== 1'b0) begin
            errors++; $display("FAIL midread_reset got oe=%b wait=%b st=%0d err=%b exp 0/0/IDLE/0",
                               mem_data_oe, mt_wait, dbg_state, err_abort);
        end
        idle_bus();
        @(posedge clk); #1 rst = 1'b0;
        exp_q.push_back(16'h7777);
        do_read(24'h000040, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [23:0] a;
        logic [15:0] d1, d2, e;
        logic        lb, ub, rlb, rub;
        for (int i = 0; i < 6; i++) begin
            a  = 24'h000100 + 24'($urandom_range(0, 15));
            d1 = 16'($urandom);
            d2 = 16'($urandom);
            lb = 1'($urandom_range(0, 1));
            ub = 1'($urandom_range(0, 1));
            rlb = 1'($urandom_range(0, 1));
            rub = 1'($urandom_range(0, 1));
            do_write(a, d1, 1'b0, 1'b0, 1'b0);
            model[a[9:0]] = d1;
            do_write(a, d2, lb, ub, 1'b0);
            if (!lb) model[a[9:0]][7:0]  = d2[7:0];
            if (!ub) model[a[9:0]][15:8] = d2[15:8];
            e = model[a[9:0]];
            if (rlb) e[7:0]  = 8'h00;
            if (rub) e[15:8] = 8'h00;
            exp_q.push_back(e);
            do_read(a, rlb, rub, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_lanes();
        test_alias();
        test_cre();
        test_abort();
        test_reset_mid_read();
        test_back_to_back();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++; $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
